pwm_capture: RTL

PWM_CAPTURE -- requirements
Module: pwm_capture

---
 rtl/pwm_capture.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/pwm_capture.sv
// PWM high-time / period capture with stuck-input timeout.
// Optional build macro PWM_CAPTURE_GLITCH_FILTER_EN adds a 3-sample level filter.
module pwm_capture #(
  parameter int PWM_INTERVAL   = 1200,
  parameter int CNT_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 4 * PWM_INTERVAL
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pwm_in,
  output logic [CNT_WIDTH-1:0] high_count,
  output logic [CNT_WIDTH-1:0] period_count,
  output logic                 meas_valid,
  output logic                 stuck,
  output logic [1:0]           state_dbg
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  localparam int WU = 5;
`else
  localparam int WU = 3;
`endif

  typedef enum logic [1:0] {IDLE, ARM, HIGH, LOW} state_t;

  state_t               state_q, state_d;
  logic                 s1_q, s2_q, hist_q, rise_q, fall_q, lvl;
  logic [WU-1:0]        wu_q;
  logic [CNT_WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, hc_q, hc_d, pc_q, pc_d;
  logic                 mv_q, mv_d, stuck_q, stuck_d;
  logic [TW-1:0]        tmo_q, tmo_d;
  logic [CNT_WIDTH:0]   sum;
  logic                 edge_seen, timeout_hit;

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  logic [1:0] sh_q;
  logic       filt_q;
  // Level only moves once three consecutive synchronized samples agree.
  assign lvl = (s2_q == sh_q[0] && s2_q == sh_q[1]) ? s2_q : filt_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_q   <= '0;
      filt_q <= 1'b0;
    end else begin
      sh_q   <= {sh_q[0], s2_q};
      filt_q <= lvl;
    end
  end
`else
  assign lvl = s2_q;
`endif

  // Edge pulses are registered so the FSM sees level and edge aligned in hist_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      hist_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      wu_q   <= '0;
    end else begin
      s1_q   <= pwm_in;
      s2_q   <= s1_q;
      hist_q <= lvl;
      rise_q <= lvl & ~hist_q;
      fall_q <= ~lvl & hist_q;
      wu_q   <= {wu_q[WU-2:0], 1'b1};
    end
  end

  assign edge_seen   = rise_q | fall_q;
  assign timeout_hit = !edge_seen && (tmo_q == TW'(TIMEOUT_CYCLES - 1));
  assign sum         = {1'b0, hi_q} + {1'b0, lo_q};

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    hc_d    = hc_q;
    pc_d    = pc_q;
    mv_d    = 1'b0;
    stuck_d = stuck_q;
    if (edge_seen)                          tmo_d = '0;
    else if (tmo_q == TW'(TIMEOUT_CYCLES))  tmo_d = tmo_q;
    else                                    tmo_d = tmo_q + 1'b1;

    case (state_q)
      // Wait for the sync pipeline to fill after reset, so the reset-cleared
      // synchronizer cannot masquerade as a low level under a held-high input.
      IDLE: if (wu_q[WU-1] && !hist_q) state_d = ARM;
      ARM: if (rise_q) begin
        state_d = HIGH;
        hi_d    = CNT_WIDTH'(1);
        lo_d    = CNT_WIDTH'(1);
      end
      HIGH: if (fall_q) begin
        state_d = LOW;
        lo_d    = CNT_WIDTH'(1);
      end else if (hi_q != '1) begin
        hi_d = hi_q + 1'b1;
      end
      LOW: if (rise_q) begin
        hc_d    = hi_q;
        pc_d    = sum[CNT_WIDTH] ? '1 : sum[CNT_WIDTH-1:0];
        mv_d    = 1'b1;
        stuck_d = 1'b0;
        state_d = HIGH;
        hi_d    = CNT_WIDTH'(1);
        lo_d    = CNT_WIDTH'(1);
      end else if (lo_q != '1) begin
        lo_d = lo_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // The timeout counter parks at its limit so a dead input reports only once.
    if (timeout_hit) begin
      stuck_d = 1'b1;
      mv_d    = 1'b1;
      hc_d    = hist_q ? '1 : '0;
      pc_d    = '1;
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      hc_q    <= '0;
      pc_q    <= '0;
      mv_q    <= 1'b0;
      stuck_q <= 1'b0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      hc_q    <= hc_d;
      pc_q    <= pc_d;
      mv_q    <= mv_d;
      stuck_q <= stuck_d;
      tmo_q   <= tmo_d;
    end
  end

  assign high_count   = hc_q;
  assign period_count = pc_q;
  assign meas_valid   = mv_q;
  assign stuck        = stuck_q;
  assign state_dbg    = state_q;

endmodule
